// File: rtl/seq_booth_mul_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
//   state_e   : controller states (IDLE, CALC, DONE)
//   BOOTH_*   : decode of the low accumulator pair {acc[1], acc[0]}
//   clog2     : bit width needed to hold values 0..value-1
package seq_booth_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Pairs 00 and 11 are no-ops and fall through to the default branch.
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/seq_booth_mul_if.sv
// Handshake bundle for seq_booth_mul.
//   in_valid/in_ready   : operand-side handshake, a/b/is_signed qualified by in_valid
//   out_valid/out_ready : result-side handshake, s qualified by out_valid
// master = the block's environment, slave = the multiplier.
interface seq_booth_mul_if #(
  parameter int WIDTH = 4
);

  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   is_signed;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     s;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, s
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, s
  );

endinterface

// File: rtl/seq_booth_mul_booth_step.sv
// One radix-2 Booth add/subtract on the upper accumulator half (no shift).
//   upper      : upper EW bits of the accumulator
//   ext_a      : extended multiplicand
//   pair       : {acc[1], acc[0]}
//   upper_next : upper bits after the add/subtract, before the shift
module seq_booth_mul_booth_step
  import seq_booth_mul_pkg::*;
#(
  parameter int EW = 5
) (
  input  logic [EW-1:0] upper,
  input  logic [EW-1:0] ext_a,
  input  logic [1:0]    pair,
  output logic [EW-1:0] upper_next
);

  always_comb begin
    upper_next = upper;
    case (pair)
      BOOTH_ADD: upper_next = upper + ext_a;
      BOOTH_SUB: upper_next = upper - ext_a;
      default:   upper_next = upper;
    endcase
  end

endmodule

// File: rtl/seq_booth_mul.sv
// Sequential radix-2 Booth multiplier with valid/ready on both sides.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : seq_booth_mul_if slave (in_valid/in_ready/a/b/is_signed,
//         out_valid/out_ready/s)
// Operands are extended to WIDTH+1 bits so that the most-negative signed
// case and the full unsigned range are both exact. One Booth step per clock
// for WIDTH+1 clocks; s = low 2*WIDTH bits of the product.
module seq_booth_mul
  import seq_booth_mul_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  seq_booth_mul_if.slave bus
);

  localparam int EW    = WIDTH + 1;
  localparam int AW    = 2 * EW + 1;
  localparam int CNT_W = clog2(WIDTH + 1);

  state_e               state_q, state_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [EW-1:0]        ext_a_q, ext_a_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   s_q, s_d;

  logic [EW-1:0]        ext_a_in;
  logic [EW-1:0]        ext_b_in;
  logic [EW-1:0]        upper_next;
  logic [AW-1:0]        stepped;
  logic [AW-1:0]        shifted;

  assign ext_a_in = bus.is_signed ? {bus.a[WIDTH-1], bus.a} : {1'b0, bus.a};
  assign ext_b_in = bus.is_signed ? {bus.b[WIDTH-1], bus.b} : {1'b0, bus.b};

  seq_booth_mul_booth_step #(
    .EW (EW)
  ) u_step (
    .upper      (acc_q[AW-1 -: EW]),
    .ext_a      (ext_a_q),
    .pair       (acc_q[1:0]),
    .upper_next (upper_next)
  );

  assign stepped = {upper_next, acc_q[EW:0]};
  assign shifted = {stepped[AW-1], stepped[AW-1:1]};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ext_a_d = ext_a_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          acc_d   = {{EW{1'b0}}, ext_b_in, 1'b0};
          ext_a_d = ext_a_in;
          cnt_d   = CNT_W'(WIDTH);
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = shifted;
        if (cnt_q == '0) begin
          // Bit 0 of the accumulator is the Booth guard bit, so the product
          // starts at bit 1.
          s_d     = shifted[2*WIDTH:1];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ext_a_q <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ext_a_q <= ext_a_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.s         = s_q;

endmodule

// File: doc/seq_booth_mul.md
Name: seq_booth_mul

Overview:
Iterative radix-2 Booth multiplier, parametrised in operand width. It is the sequential, handshaked successor of the 4-bit combinational signed array multiplier. It adds a per-transaction signed/unsigned mode and valid/ready flow control on both sides, and spends one clock per Booth step instead of a full array. It sits as the exact reference datapath beside the approximate log multipliers and feeds their error-measurement benches.

Parameters:
WIDTH, 4, operand width in bits; legal range 2..32; the product is 2*WIDTH bits.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair and mode are valid
in_ready  output  1  block can accept an operand pair
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
is_signed  input  1  1: a and b are two's complement; 0: unsigned; sampled with the operands
out_valid  output  1  product s is valid
out_ready  input  1  consumer accepts s
s  output  2*WIDTH  product, low 2*WIDTH bits of the exact result

Behaviour:
- Reset (asynchronous assert, any state): state=IDLE, in_ready=1, out_valid=0, s=0, internal accumulator and counter cleared.
- Reset mid-operation: any in-flight or held result is discarded, with no output pulse. After rst deasserts, the first accept is on the next clock edge where in_valid=1.
- States:
  - IDLE: in_ready=1. If in_valid=1 at a clock edge, capture the operands and go to CALC.
  - CALC: in_ready=0, out_valid=0. Perform one Booth step per cycle for WIDTH+1 cycles, tracked by a down-counter.
  - DONE: out_valid=1, s held stable. When out_ready=1 at a clock edge, go to IDLE.
- Capture: extend a and b to WIDTH+1 bits. Sign-extend if is_signed=1, zero-extend otherwise. Accumulator = {WIDTH+1 zeros, ext_b, 1'b0}.
- Booth step, on the low pair {acc[1],acc[0]}:
  - 01: add ext_a to the upper WIDTH+1 bits.
  - 10: subtract ext_a from the upper WIDTH+1 bits.
  - 00 or 11: no operation.
  - Then arithmetic-shift the whole accumulator right by 1.
  - Arithmetic is (WIDTH+1)-bit two's complement; the final product is 2*WIDTH+2 bits and s takes the low 2*WIDTH.
- Latency:
  - An accept at edge N gives out_valid=1 after edge N+WIDTH+1.
  - With out_ready tied high, the next accept is no earlier than edge N+WIDTH+3 (one IDLE cycle).
  - No bypass from DONE directly to CALC.
- Backpressure: s and out_valid must not change while out_valid=1 and out_ready=0. in_valid is ignored outside IDLE.
- The is_signed latched at accept governs the whole transaction; mid-CALC changes on the input have no effect.
- Boundaries:
  - Most-negative × most-negative in signed mode is exact (e.g. WIDTH=4: -8*-8 = 0x40).
  - Max × max in unsigned mode is exact (15*15 = 0xE1).
  - Both cases are exact because of the WIDTH+1 extension.
- No X on any output after reset; s keeps its last value in IDLE.

Decomposition:
- Shared package mul_pkg:
  - state enum {IDLE, CALC, DONE}
  - Booth-pair decode localparams
  - function clog2 for the counter width
- Sub-module booth_step (combinational):
  - inputs: WIDTH+1 upper accumulator bits, ext_a, pair code
  - output: the next upper bits before the shift
- The top module holds the FSM, the counter, the accumulator and the handshake.

Test Plan:
1. WIDTH=4, signed, a=1010 (-6), b=0101 (5), out_ready=1 -> s=0xE2 (-30). out_valid rises exactly 5 cycles after the accept edge and stays high for 1 cycle.
2. WIDTH=4, a=1111, b=1111 -> signed gives s=0x01; unsigned gives s=0xE1. Also a=1000, b=0111 -> signed gives 0xC8 (-56); unsigned gives 0x38 (56).
3. Backpressure: after result 0x40 (signed -8*-8), hold out_ready=0 for 3 cycles while pulsing in_valid with new operands -> s stays 0x40, in_ready=0, the new operands are not captured. Release out_ready -> IDLE, in_ready=1 one cycle later.
4. Reset mid-CALC: assert rst on the 2nd CALC cycle -> out_valid=0, s=0, in_ready=1 immediately (asynchronously). The next transaction 4*3 gives 0x0C with normal latency.
5. WIDTH=8, signed: -128*-128 -> 0x4000; 127*-128 -> 0xC080; 0*-1 -> 0x0000. Each has latency 9 cycles.
6. Exhaustive WIDTH=4, both modes, random out_ready stalls: all 512 results match the golden $signed/$unsigned product, with no dropped or duplicated outputs.
